// File: rtl/spi_adc_slave_emulator.sv
// SPI slave emulating a 16-bit-frame multiplexed ADC. SCK/CSbar/MOSI are oversampled on CLK,
// the command word is shifted in, and {channel, sample} is shifted out MSB first. The channel
// field returned reflects the selection in force at frame start, so it lags the command by one frame.
module spi_adc_slave_emulator #(
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned ADDR_BITS  = 4,
   parameter int unsigned DATA_BITS  = 12
) (
   input  logic                  CLK,
   input  logic                  RSTbar,
   input  logic                  SCK,
   input  logic                  CSbar,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  MISO_OE,
   input  logic [DATA_BITS-1:0]  SAMPLE,
   output logic [ADDR_BITS-1:0]  CH_SEL,
   output logic [FRAME_BITS-1:0] RX_WORD,
   output logic                  RX_VALID,
   output logic                  FRAME_ERR
);

   localparam int unsigned CntW    = $clog2(FRAME_BITS + 1);
   // Command field layout: write-enable bit and channel address position.
   localparam int unsigned WrBit   = 12;
   localparam int unsigned AddrLsb = 7;

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [FRAME_BITS-2:0] rx_shift_q, rx_shift_d;
   // Holds the bits still to be sent after the one currently on MISO.
   logic [FRAME_BITS-2:0] tx_shift_q, tx_shift_d;
   logic                  miso_q, miso_d;
   logic                  miso_oe_q, miso_oe_d;
   logic [ADDR_BITS-1:0]  ch_sel_q, ch_sel_d;
   logic [FRAME_BITS-1:0] rx_word_q, rx_word_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  frame_err_q, frame_err_d;

   logic cs_s1_q, cs_s2_q, cs_prev_q;
   logic sck_s1_q, sck_s2_q, sck_prev_q;
   logic mosi_s1_q, mosi_s2_q;

   logic                  cs_fall, cs_rise, sck_rise, sck_fall;
   logic [FRAME_BITS-1:0] rx_full;

   // Two-stage synchronisers plus one delay stage for edge detection; idle levels on reset.
   always_ff @(posedge CLK) begin
      if (!RSTbar) begin
         cs_s1_q    <= 1'b1;
         cs_s2_q    <= 1'b1;
         cs_prev_q  <= 1'b1;
         sck_s1_q   <= 1'b0;
         sck_s2_q   <= 1'b0;
         sck_prev_q <= 1'b0;
         mosi_s1_q  <= 1'b0;
         mosi_s2_q  <= 1'b0;
      end else begin
         cs_s1_q    <= CSbar;
         cs_s2_q    <= cs_s1_q;
         cs_prev_q  <= cs_s2_q;
         sck_s1_q   <= SCK;
         sck_s2_q   <= sck_s1_q;
         sck_prev_q <= sck_s2_q;
         mosi_s1_q  <= MOSI;
         mosi_s2_q  <= mosi_s1_q;
      end
   end

   // Edge strobes from the synchronised pins.
   always_comb begin
      cs_fall  = cs_prev_q & ~cs_s2_q;
      cs_rise  = ~cs_prev_q & cs_s2_q;
      sck_rise = ~sck_prev_q & sck_s2_q;
      sck_fall = sck_prev_q & ~sck_s2_q;
      rx_full  = {rx_shift_q, mosi_s2_q};
   end

   // Frame FSM next-state and output logic.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      miso_d      = miso_q;
      miso_oe_d   = miso_oe_q;
      ch_sel_d    = ch_sel_q;
      rx_word_d   = rx_word_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            if (cs_fall) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (cs_rise) begin
               state_d   = StIdle;
               miso_d    = 1'b0;
               miso_oe_d = 1'b0;
            end else begin
               // Response is captured here; later SAMPLE changes do not affect this frame.
               {miso_d, tx_shift_d} = {ch_sel_q, SAMPLE};
               miso_oe_d = 1'b1;
               count_d   = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            if (cs_rise) begin
               state_d     = StIdle;
               miso_d      = 1'b0;
               miso_oe_d   = 1'b0;
               frame_err_d = (count_q != '0);
            end else if (sck_rise) begin
               rx_shift_d = rx_full[FRAME_BITS-2:0];
               count_d    = count_q + CntW'(1);
               if (count_q == CntW'(FRAME_BITS - 1)) begin
                  state_d    = StDone;
                  miso_d     = 1'b0;
                  rx_word_d  = rx_full;
                  rx_valid_d = 1'b1;
                  if (rx_full[WrBit]) begin
                     ch_sel_d = rx_full[AddrLsb +: ADDR_BITS];
                  end
               end
            end else if (sck_fall && (count_q != '0)) begin
               // Ignore a fall before the first rise so the MSB is not skipped.
               miso_d     = tx_shift_q[FRAME_BITS-2];
               tx_shift_d = {tx_shift_q[FRAME_BITS-3:0], 1'b0};
            end
         end
         StDone: begin
            miso_d = 1'b0;
            if (cs_rise) begin
               state_d   = StIdle;
               miso_oe_d = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RSTbar) begin
         state_q     <= StIdle;
         count_q     <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         ch_sel_q    <= '0;
         rx_word_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         ch_sel_q    <= ch_sel_d;
         rx_word_q   <= rx_word_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign MISO      = miso_q;
   assign MISO_OE   = miso_oe_q;
   assign CH_SEL    = ch_sel_q;
   assign RX_WORD   = rx_word_q;
   assign RX_VALID  = rx_valid_q;
   assign FRAME_ERR = frame_err_q;

endmodule
